// File: rtl/proj2d_sequencer.sv
// Sequential pinhole projection of a 3D source position onto 2D pixel coordinates.
// Both quotients share one restoring divider. Define PROJ2D_CLAMP_EN to clamp the scaled products to the image size.
module proj2d_sequencer #(
  parameter logic [15:0] FX     = 16'd185,
  parameter logic [15:0] FY     = 16'd185,
  parameter logic [15:0] CX     = 16'd105,
  parameter logic [15:0] CY     = 16'd77,
  parameter logic [15:0] RATE   = 16'd19,
  parameter logic [15:0] WIDTH  = 16'd4000,
  parameter logic [15:0] HEIGHT = 16'd2900
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] z,
  input  logic [1:0]  quadrant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] x_2d,
  output logic [15:0] y_2d,
  output logic        out_err,
  output logic        busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CALC  = 3'd1;
  localparam logic [2:0] S_DIV_X = 3'd2;
  localparam logic [2:0] S_DIV_Y = 3'd3;
  localparam logic [2:0] S_POST  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [4:0] LAST_ITER = 5'd24;

  logic [2:0]  state_q, state_d;
  logic [15:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [1:0]  quad_q, quad_d;
  logic [25:0] num_y_q, num_y_d;
  logic [24:0] div_q, div_d;
  logic [15:0] rem_q, rem_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [24:0] qx_q, qx_d, qy_q, qy_d;
  logic        err_q, err_d;
  logic [15:0] xo_q, xo_d, yo_q, yo_d;
  logic        oerr_q, oerr_d, ovalid_q, ovalid_d;

  logic [25:0] num_x_s, num_y_s;
  logic [16:0] shifted_s;
  logic        ge_s;
  logic [15:0] rem_step_s;
  logic [24:0] div_step_s;
  logic [15:0] tx_s, ty_s, x_mir_s, y_mir_s;
`ifdef PROJ2D_CLAMP_EN
  logic [29:0] tx_full_s, ty_full_s;
`endif

  assign num_x_s = ({10'd0, FX} * {10'd0, x_q}) + ({10'd0, CX} * {10'd0, z_q});
  assign num_y_s = ({10'd0, FY} * {10'd0, y_q}) + ({10'd0, CY} * {10'd0, z_q});

  // One restoring-division step; the remainder stays below z, so 16 bits suffice.
  always_comb begin
    shifted_s  = {rem_q, div_q[24]};
    ge_s       = (shifted_s >= {1'b0, z_q});
    rem_step_s = ge_s ? (shifted_s[15:0] - z_q) : shifted_s[15:0];
    div_step_s = {div_q[23:0], ge_s};
  end

  // Pixel scaling and per-quadrant mirroring of the two quotients.
  always_comb begin
`ifdef PROJ2D_CLAMP_EN
    tx_full_s = {5'd0, qx_q} * {14'd0, RATE};
    ty_full_s = {5'd0, qy_q} * {14'd0, RATE};
    tx_s = (tx_full_s > {14'd0, WIDTH})  ? WIDTH  : tx_full_s[15:0];
    ty_s = (ty_full_s > {14'd0, HEIGHT}) ? HEIGHT : ty_full_s[15:0];
`else
    tx_s = 16'({5'd0, qx_q} * {14'd0, RATE});
    ty_s = 16'({5'd0, qy_q} * {14'd0, RATE});
`endif
    x_mir_s = (quad_q[0] == quad_q[1]) ? tx_s : (WIDTH - tx_s);
    y_mir_s = quad_q[1] ? ty_s : (HEIGHT - ty_s);
  end

  // Sequencer next-state and datapath load decisions.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    quad_d   = quad_q;
    num_y_d  = num_y_q;
    div_d    = div_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    qx_d     = qx_q;
    qy_d     = qy_q;
    err_d    = err_q;
    xo_d     = xo_q;
    yo_d     = yo_q;
    oerr_d   = oerr_q;
    ovalid_d = ovalid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d     = x;
          y_d     = y;
          z_d     = z;
          quad_d  = quadrant;
          state_d = S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        num_y_d = num_y_s;
        div_d   = num_x_s[24:0];
        rem_d   = {15'd0, num_x_s[25]};
        cnt_d   = 5'd0;
        if (z_q == 16'd0) begin
          qx_d    = 25'd0;
          qy_d    = 25'd0;
          err_d   = 1'b1;
          state_d = S_POST;
        end else begin
          err_d   = 1'b0;
          state_d = S_DIV_X;
        end
      end
      S_DIV_X: begin
        div_d = div_step_s;
        rem_d = rem_step_s;
        cnt_d = cnt_q + 5'd1;
        // Last x step hands the shared divider straight over to num_y.
        if (cnt_q == LAST_ITER) begin
          qx_d    = div_step_s;
          div_d   = num_y_q[24:0];
          rem_d   = {15'd0, num_y_q[25]};
          cnt_d   = 5'd0;
          state_d = S_DIV_Y;
        end else begin
          state_d = S_DIV_X;
        end
      end
      S_DIV_Y: begin
        div_d = div_step_s;
        rem_d = rem_step_s;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_ITER) begin
          qy_d    = div_step_s;
          cnt_d   = 5'd0;
          state_d = S_POST;
        end else begin
          state_d = S_DIV_Y;
        end
      end
      S_POST: begin
        xo_d     = x_mir_s;
        yo_d     = y_mir_s;
        oerr_d   = err_q;
        ovalid_d = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          ovalid_d = 1'b0;
          state_d  = S_IDLE;
        end else begin
          state_d  = S_DONE;
        end
      end
      default: begin
        ovalid_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      x_q      <= 16'd0;
      y_q      <= 16'd0;
      z_q      <= 16'd0;
      quad_q   <= 2'd0;
      num_y_q  <= 26'd0;
      div_q    <= 25'd0;
      rem_q    <= 16'd0;
      cnt_q    <= 5'd0;
      qx_q     <= 25'd0;
      qy_q     <= 25'd0;
      err_q    <= 1'b0;
      xo_q     <= 16'd0;
      yo_q     <= 16'd0;
      oerr_q   <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      quad_q   <= quad_d;
      num_y_q  <= num_y_d;
      div_q    <= div_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      qx_q     <= qx_d;
      qy_q     <= qy_d;
      err_q    <= err_d;
      xo_q     <= xo_d;
      yo_q     <= yo_d;
      oerr_q   <= oerr_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = ovalid_q;
  assign x_2d      = xo_q;
  assign y_2d      = yo_q;
  assign out_err   = oerr_q;

endmodule

// File: tb/tb_proj2d_sequencer.sv
// Scoreboard bench for proj2d_sequencer: expected points come from an independent
// arithmetic model and are compared when the sequencer raises out_valid.
module tb_proj2d_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_err, busy;
  logic [15:0] x, y, z, x_2d, y_2d;
  logic [1:0]  quadrant;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] ex;
    logic [15:0] ey;
    logic        ee;
    int          lat;
  } exp_t;
  exp_t sb[$];

  proj2d_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .z(z), .quadrant(quadrant), .out_valid(out_valid),
    .out_ready(out_ready), .x_2d(x_2d), .y_2d(y_2d), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [15:0] px, py, pz, input logic [1:0] pq);
    longint nx, ny, qx, qy, tx, ty;
    exp_t r;
    nx = 185 * longint'(px) + 105 * longint'(pz);
    ny = 185 * longint'(py) + 77 * longint'(pz);
    if (pz == 16'd0) begin
      qx = 0;
      qy = 0;
    end else begin
      qx = nx / longint'(pz);
      qy = ny / longint'(pz);
    end
    tx = qx * 19;
    ty = qy * 19;
`ifdef PROJ2D_CLAMP_EN
    if (tx > 4000) tx = 4000;
    if (ty > 2900) ty = 2900;
`else
    tx = tx % 65536;
    ty = ty % 65536;
`endif
    r.ex  = (pq[0] == pq[1]) ? 16'(tx) : 16'(4000 - tx);
    r.ey  = pq[1] ? 16'(ty) : 16'(2900 - ty);
    r.ee  = (pz == 16'd0);
    r.lat = (pz == 16'd0) ? 2 : 52;
    return r;
  endfunction

  // Called at posedge+1; returns one posedge+1 after the accept edge.
  task automatic drive_sample(input logic [15:0] px, py, pz, input logic [1:0] pq);
    int guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    x = px; y = py; z = pz; quadrant = pq;
    in_valid = 1'b1;
    sb.push_back(model(px, py, pz, pq));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_output(output int lat);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    x = 16'd0; y = 16'd0; z = 16'd0; quadrant = 2'd0;
    #12;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (x_2d !== 16'd0 || y_2d !== 16'd0) begin n_err++; $display("FAIL reset_xy got %0d,%0d want 0,0", x_2d, y_2d); end
    n_cmp++; if (out_err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", out_err); end
    n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL reset_busy busy=%b in_ready=%b want 0/1", busy, in_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_projection;
    logic [15:0] tx_t[6] = '{16'd100, 16'd100, 16'd100, 16'd1000, 16'd1000, 16'd65535};
    logic [15:0] ty_t[6] = '{16'd50, 16'd50, 16'd50, 16'd0, 16'd0, 16'd65535};
    logic [15:0] tz_t[6] = '{16'd1000, 16'd1000, 16'd1000, 16'd100, 16'd100, 16'd1};
    logic [1:0]  tq_t[6] = '{2'b00, 2'b01, 2'b11, 2'b01, 2'b00, 2'b10};
    exp_t e;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_sample(tx_t[i], ty_t[i], tz_t[i], tq_t[i]);
      wait_output(lat);
      e = (sb.size() > 0) ? sb.pop_front() : '{16'd0, 16'd0, 1'b0, 0};
      n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL proj_latency[%0d] got %0d want %0d", i, lat, e.lat); end
      n_cmp++; if (x_2d !== e.ex) begin n_err++; $display("FAIL proj_x[%0d] got %0d want %0d", i, x_2d, e.ex); end
      n_cmp++; if (y_2d !== e.ey) begin n_err++; $display("FAIL proj_y[%0d] got %0d want %0d", i, y_2d, e.ey); end
      n_cmp++; if (out_err !== e.ee) begin n_err++; $display("FAIL proj_err[%0d] got %b want %b", i, out_err, e.ee); end
      @(posedge clk); #1;
      n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL proj_release[%0d] in_ready=%b out_valid=%b want 1/0", i, in_ready, out_valid); end
    end
  endtask

  task automatic test_zero_z;
    exp_t e;
    int lat;
    out_ready = 1'b1;
    drive_sample(16'd1234, 16'd4321, 16'd0, 2'b00);
    wait_output(lat);
    e = (sb.size() > 0) ? sb.pop_front() : '{16'd0, 16'd0, 1'b0, 0};
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL zero_latency got %0d want 2", lat); end
    n_cmp++; if (out_err !== 1'b1) begin n_err++; $display("FAIL zero_err got %b want 1", out_err); end
    n_cmp++; if (x_2d !== e.ex || y_2d !== e.ey) begin n_err++; $display("FAIL zero_xy got %0d,%0d want %0d,%0d", x_2d, y_2d, e.ex, e.ey); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    exp_t e;
    int lat;
    out_ready = 1'b0;
    drive_sample(16'd100, 16'd50, 16'd1000, 2'b10);
    wait_output(lat);
    e = (sb.size() > 0) ? sb.pop_front() : '{16'd0, 16'd0, 1'b0, 0};
    n_cmp++; if (lat !== 52) begin n_err++; $display("FAIL bp_latency got %0d want 52", lat); end
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        in_valid = 1'b1;
        x = 16'd999; z = 16'd7;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold[%0d] out_valid=%b in_ready=%b want 1/0", i, out_valid, in_ready); end
      n_cmp++; if (x_2d !== e.ex || y_2d !== e.ey || out_err !== e.ee) begin n_err++; $display("FAIL bp_data[%0d] got %0d,%0d want %0d,%0d", i, x_2d, y_2d, e.ex, e.ey); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_pulse_ignored busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int lat;
    out_ready = 1'b1;
    drive_sample(16'd500, 16'd300, 16'd200, 2'b01);
    repeat (30) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy_before got %b want 1", busy); end
    rst_n = 1'b0;
    if (sb.size() > 0) sb.delete(sb.size() - 1);
    #1;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_state out_valid=%b busy=%b in_ready=%b want 0/0/1", out_valid, busy, in_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    drive_sample(16'd100, 16'd50, 16'd1000, 2'b01);
    wait_output(lat);
    e = (sb.size() > 0) ? sb.pop_front() : '{16'd0, 16'd0, 1'b0, 0};
    n_cmp++; if (lat !== 52) begin n_err++; $display("FAIL midrst_latency got %0d want 52", lat); end
    n_cmp++; if (x_2d !== e.ex || y_2d !== e.ey || out_err !== e.ee) begin n_err++; $display("FAIL midrst_data got %0d,%0d,%b want %0d,%0d,%b", x_2d, y_2d, out_err, e.ex, e.ey, e.ee); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int lat;
    logic [15:0] rx, ry, rz;
    logic [1:0]  rq;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      rz = 16'($urandom_range(1, 65535));
      rq = 2'($urandom);
      drive_sample(rx, ry, rz, rq);
      wait_output(lat);
      e = (sb.size() > 0) ? sb.pop_front() : '{16'd0, 16'd0, 1'b0, 0};
      n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL b2b_latency[%0d] got %0d want %0d", i, lat, e.lat); end
      n_cmp++; if (x_2d !== e.ex || y_2d !== e.ey || out_err !== e.ee) begin n_err++; $display("FAIL b2b_data[%0d] in=%0d,%0d,%0d,%0d got %0d,%0d want %0d,%0d", i, rx, ry, rz, rq, x_2d, y_2d, e.ex, e.ey); end
      @(posedge clk); #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready[%0d] got %b want 1", i, in_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_projection();
    test_zero_z();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
